// File: rtl/seq_detector_param.sv
// seq_detector_param: detects a LEN-bit pattern on a 1-bit serial stream.
// The pattern register loads from PATTERN at reset and can be reloaded at run time.
// Matching can be overlapping or non-overlapping. Input is qualified by in_valid.
// A saturating counter records the number of matches.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   in         serial data bit
//   in_valid   in is sampled only when high
//   pat_load   load pat_in as the new pattern (hist/fill cleared, in discarded)
//   pat_in     new pattern, MSB is the first bit received
//   cnt_clr    synchronous clear of match_cnt (wins over a same-cycle match)
//   out        registered one-cycle match pulse
//   match_cnt  saturating match count
module seq_detector_param #(
   parameter int unsigned    LEN     = 4,
   parameter logic [LEN-1:0] PATTERN = 4'b1001,
   parameter int unsigned    OVERLAP = 1,
   parameter int unsigned    CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in,
   input  logic             in_valid,
   input  logic             pat_load,
   input  logic [LEN-1:0]   pat_in,
   input  logic             cnt_clr,
   output logic             out,
   output logic [CNT_W-1:0] match_cnt
);

   // fill counts 0..LEN-1, so $clog2(LEN) bits are enough (LEN >= 2).
   localparam int unsigned        FILL_W   = $clog2(LEN);
   localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(LEN - 1);

   logic [LEN-1:0]    pat_q, pat_d;
   logic [LEN-2:0]    hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              out_q, out_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [LEN-1:0]    cand;
   logic              match;

   assign cand = {hist_q, in};

   always_comb begin
      pat_d  = pat_q;
      hist_d = hist_q;
      fill_d = fill_q;
      match  = 1'b0;

      if (pat_load) begin
         // A reload restarts detection; the same-cycle input bit is dropped.
         pat_d  = pat_in;
         hist_d = '0;
         fill_d = '0;
      end else if (in_valid) begin
         match  = (fill_q == FILL_MAX) && (cand == pat_q);
         hist_d = cand[LEN-2:0];
         if (match && (OVERLAP == 0)) begin
            // Non-overlapping: a new match needs LEN fresh bits.
            fill_d = '0;
         end else if (fill_q != FILL_MAX) begin
            fill_d = fill_q + FILL_W'(1);
         end
      end

      out_d = match;

      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (match && !(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pat_q  <= PATTERN;
         hist_q <= '0;
         fill_q <= '0;
         out_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         pat_q  <= pat_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         out_q  <= out_d;
         cnt_q  <= cnt_d;
      end
   end

   assign out       = out_q;
   assign match_cnt = cnt_q;

endmodule
